// File: rtl/jk_pkg.sv
// Shared JK opcode encoding and next-state helper for the jk flip-flop bank.
package jk_pkg;

  // Opcode is the {j, k} input pair taken as a 2-bit value.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(jk_op_e op, logic q);
    logic q_next;
    case (op)
      JK_HOLD: q_next = q;
      JK_CLR:  q_next = 1'b0;
      JK_SET:  q_next = 1'b1;
      JK_TOG:  q_next = ~q;
      // Unknown j/k must show up as X on the bit rather than be masked.
      default: q_next = 1'bx;
    endcase
    return q_next;
  endfunction

endpackage

// File: rtl/jk_if.sv
// JK bank data signals; qn exists only when JK_QN_EN is defined.
interface jk_if #(
    parameter int unsigned WIDTH = 1
) ();

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
`ifdef JK_QN_EN
  logic [WIDTH-1:0] qn;

  modport master(output j, output k, input q, input qn);
  modport slave(input j, input k, output q, output qn);
`else
  modport master(output j, output k, input q);
  modport slave(input j, input k, output q);
`endif

endinterface

// File: rtl/jk_bit.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_bit
  import jk_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = jk_next(jk_op_e'({j_i, k_i}), q_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk.sv
// WIDTH-bit bank of independent JK flip-flops; define JK_QN_EN to add the qn output.
module jk #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input logic clk_i,
    input logic reset_i,
    jk_if.slave bus
);

  logic [WIDTH-1:0] q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit #(
        .RESET_VAL(RESET_VAL[i])
    ) u_bit (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .j_i    (bus.j[i]),
        .k_i    (bus.k[i]),
        .q_o    (q[i])
    );
  end

  assign bus.q = q;
`ifdef JK_QN_EN
  // Derived from the same register, so qn can never diverge from ~q.
  assign bus.qn = ~q;
`endif

endmodule

// File: tb/tb_jk.sv
// Directed bench for jk: a 1-bit instance and a 4-bit instance (RESET_VAL 4'b1010) share clk/reset.
module tb_jk;

  typedef struct {
    logic       rst;
    logic       j1;
    logic       k1;
    logic       q1;
    logic [3:0] j4;
    logic [3:0] k4;
    logic [3:0] q4;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  jk_if #(.WIDTH(1)) bus1 ();
  jk_if #(.WIDTH(4)) bus4 ();

  jk #(
      .WIDTH    (1),
      .RESET_VAL(1'b0)
  ) u_dut1 (
      .clk_i  (clk),
      .reset_i(reset),
      .bus    (bus1)
  );

  jk #(
      .WIDTH    (4),
      .RESET_VAL(4'b1010)
  ) u_dut4 (
      .clk_i  (clk),
      .reset_i(reset),
      .bus    (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic q1, input logic [3:0] q4);
    check({tag, " q1"}, {3'b000, bus1.q}, {3'b000, q1});
    check({tag, " q4"}, bus4.q, q4);
`ifdef JK_QN_EN
    check({tag, " qn1"}, {3'b000, bus1.qn}, {3'b000, ~q1});
    check({tag, " qn4"}, bus4.qn, ~q4);
`endif
  endtask

  vec_t       vecs[18];
  logic       e1;
  logic [3:0] e4;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus1.j = 1'b0;
    bus1.k = 1'b0;
    bus4.j = 4'b0000;
    bus4.k = 4'b0000;

    //         rst   j1    k1    q1    j4       k4       q4
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1010};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1010};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1010};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1010};
    // 4-bit: bit3 tog 1->0, bit2 set, bit1 clr, bit0 hold 0 -> 0100
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1100, 4'b1010, 4'b0100};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0111};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1000};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0101};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0101};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0101};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0101};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0101};
    // Reset lands in the middle of a toggle run, then toggling resumes.
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1010};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0101};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1010};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1010};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      reset  = vecs[i].rst;
      bus1.j = vecs[i].j1;
      bus1.k = vecs[i].k1;
      bus4.j = vecs[i].j4;
      bus4.k = vecs[i].k4;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].q1, vecs[i].q4);
    end

    // Inputs and a reset glitch between edges must not reach q.
    @(negedge clk);
    bus1.j = 1'b1;
    bus1.k = 1'b0;
    bus4.j = 4'b0000;
    bus4.k = 4'b0000;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    check_all("mid-cycle", 1'b0, 4'b1010);
    @(posedge clk);
    #1;
    check_all("glitch-ignored", 1'b1, 4'b1010);

    // Continuous toggle: q runs at clk/2.
    e1 = 1'b1;
    e4 = 4'b1010;
    @(negedge clk);
    bus1.j = 1'b1;
    bus1.k = 1'b1;
    bus4.j = 4'b1111;
    bus4.k = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      e1 = ~e1;
      e4 = ~e4;
      check_all($sformatf("toggle%0d", n), e1, e4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
